am2925_seq: RTL and testbench
=============================

AM2925_SEQ -- requirements
Module: am2925_seq

Interface
REQ-001 The module SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk  in  1  system clock; all state changes occur on its rising edge.
REQ-003 rst_  in  1  asynchronous active-low reset.
REQ-004 cyc_end  in  1  high for exactly one clk on the last clock of each microcycle.
REQ-005 len  in  4  requested microcycle length, in clocks.
REQ-006 req0_, req1_  in  1 each  active-low bus requests from requester 0 (CPU) and requester 1 (DMA).
REQ-007 wst0, wst1  in  4 each  wait-state count for each requester.
REQ-008 mem_rdy_  in  1  active-low memory ready.
REQ-009 waitack_  in  1  active-low acknowledge from the clock generator that it is held in wait.
REQ-010 l3, l2, l1  out  1 each  microcycle length code to the clock generator.
REQ-011 waitreq_, ready_  out  1 each  active-low wait request and ready to the clock generator.
REQ-012 gnt0_, gnt1_  out  1 each  active-low bus grants.
REQ-013 done_  out  1  active-low, one-clk pulse marking the end of a transaction.
REQ-014 tmo  out  1  high means the last transaction ended by timeout.

Function
REQ-015 Length code map {l3,l2,l1}: 3->000, 4->001, 5->101, 6->111, 7->011, 8->010, 9->110, 10->100.
REQ-016 len values 0-2 SHALL clamp to 3; len values 11-15 SHALL clamp to 10.
REQ-017 l3..l1 SHALL update only on a clk where cyc_end=1, so the code stays stable within a microcycle.
REQ-018 The FSM SHALL have exactly these states: IDLE, WREQ, COUNT, MEMW, RDY.
REQ-019 IDLE: on cyc_end=1 with at least one request low, assert the selected grant; load cnt with that requester's wst; go to WREQ.
  - Requests sampled outside cyc_end are ignored.
  - A request withdrawn before that cyc_end SHALL receive no grant.
REQ-020 Arbitration SHALL be round-robin: with both requests low, grant the requester not granted last.
  - The priority pointer SHALL point at requester 0 after reset.
REQ-021 WREQ: waitreq_=0; when waitack_=0, set waitreq_=1 on the next clk and go to COUNT.
  - If waitack_ stays 1 for 15 clks, go to RDY with tmo=1.
REQ-022 COUNT: decrement cnt once per clk; when cnt=0, go to MEMW.
  - wst=0 SHALL pass through COUNT in one clk.
REQ-023 MEMW: go to RDY on the first clk with mem_rdy_=0.
  - An 8-bit watchdog SHALL force RDY with tmo=1 after 255 clks.
REQ-024 RDY: ready_=0, done_=0 and the grant deasserted, all for exactly one clk; then go to IDLE.
  - tmo holds until the next grant, then clears.
REQ-025 A granted transaction SHALL complete even if its request is withdrawn.
  - New requests during a transaction SHALL wait for IDLE.
REQ-026 Both grants SHALL NEVER be low simultaneously.
REQ-027 waitreq_ and ready_ SHALL NEVER be low simultaneously.

Reset
REQ-028 rst_=0 SHALL immediately force the following, including mid-transaction:
  - state=IDLE, cnt=0, watchdog=0, priority pointer at requester 0;
  - {l3,l2,l1}=000, waitreq_=1, ready_=1, gnt0_=1, gnt1_=1, done_=1, tmo=0.
REQ-029 After rst_ rises, the first grant SHALL be possible at the first cyc_end.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - Code map: sweep len 0..15, each with a cyc_end pulse -> l-codes per REQ-015/016; len=2 -> 000, len=12 -> 100; no change without cyc_end.
  - Single transaction: req0_=0, wst0=2, waitack_ low 1 clk after waitreq_, mem_rdy_=0 -> gnt0_ low at cyc_end; waitreq_ low until waitack_; ready_ and done_ low exactly one clk, 2+1 clks after waitreq_ rises.
  - Round-robin: both requests held low for 4 transactions -> grants alternate 0,1,0,1; never both low.
  - Timeouts: waitack_ held 1 -> RDY after 15 clks with tmo=1. mem_rdy_ held 1 -> ready_ pulse after 255 clks in MEMW with tmo=1.
  - Reset mid-operation: rst_=0 while in COUNT -> all outputs immediately at reset values; a req1_ pending after reset is still served after req0_ per the pointer rule.

Source files
------------

// File: rtl/am2925_seq.sv
// Microcycle sequencer: length-code generation for the clock generator plus a
// two-requester round-robin bus arbiter with wait handshake, wait states and timeouts.
module am2925_seq (
  input  logic       clk,
  input  logic       rst_,
  input  logic       cyc_end,
  input  logic [3:0] len,
  input  logic       req0_,
  input  logic       req1_,
  input  logic [3:0] wst0,
  input  logic [3:0] wst1,
  input  logic       mem_rdy_,
  input  logic       waitack_,
  output logic       l3,
  output logic       l2,
  output logic       l1,
  output logic       waitreq_,
  output logic       ready_,
  output logic       gnt0_,
  output logic       gnt1_,
  output logic       done_,
  output logic       tmo
);

  typedef enum logic [2:0] {IDLE, WREQ, COUNT, MEMW, RDY} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] wd;
  logic       ptr;
  logic [2:0] code_nxt;
  logic       pick1;

  // Out-of-range lengths fall into the default arm: 0-3 give the 3-clock code, 10-15 the 10-clock code.
  always_comb begin
    code_nxt = 3'b000;
    case (len)
      4'd4:    code_nxt = 3'b001;
      4'd5:    code_nxt = 3'b101;
      4'd6:    code_nxt = 3'b111;
      4'd7:    code_nxt = 3'b011;
      4'd8:    code_nxt = 3'b010;
      4'd9:    code_nxt = 3'b110;
      default: code_nxt = (len >= 4'd10) ? 3'b100 : 3'b000;
    endcase
  end

  // ptr=1 means requester 1 wins a tie.
  assign pick1 = !req1_ && (req0_ || ptr);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      wd           <= 8'd0;
      ptr          <= 1'b0;
      {l3, l2, l1} <= 3'b000;
      waitreq_     <= 1'b1;
      ready_       <= 1'b1;
      gnt0_        <= 1'b1;
      gnt1_        <= 1'b1;
      done_        <= 1'b1;
      tmo          <= 1'b0;
    end else begin
      if (cyc_end)
        {l3, l2, l1} <= code_nxt;

      case (state)
        IDLE: begin
          if (cyc_end && !(req0_ && req1_)) begin
            gnt0_    <= pick1;
            gnt1_    <= !pick1;
            ptr      <= !pick1;
            cnt      <= pick1 ? wst1 : wst0;
            wd       <= 8'd0;
            tmo      <= 1'b0;
            waitreq_ <= 1'b0;
            state    <= WREQ;
          end
        end
        WREQ: begin
          if (!waitack_) begin
            waitreq_ <= 1'b1;
            state    <= COUNT;
          end else if (wd == 8'd14) begin
            waitreq_ <= 1'b1;
            tmo      <= 1'b1;
            ready_   <= 1'b0;
            done_    <= 1'b0;
            gnt0_    <= 1'b1;
            gnt1_    <= 1'b1;
            state    <= RDY;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        COUNT: begin
          // Leave as cnt reaches zero; a zero wait-state count still spends one clock here.
          if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            wd    <= 8'd0;
            state <= MEMW;
          end
        end
        MEMW: begin
          if (!mem_rdy_ || wd == 8'd254) begin
            tmo    <= mem_rdy_;
            ready_ <= 1'b0;
            done_  <= 1'b0;
            gnt0_  <= 1'b1;
            gnt1_  <= 1'b1;
            state  <= RDY;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        RDY: begin
          ready_ <= 1'b1;
          done_  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_am2925_seq.sv
// Directed bench for am2925_seq: expected grants/codes queued at stimulus time, checked on output.
module tb_am2925_seq;

  logic       clk = 1'b0;
  logic       rst_, cyc_end, req0_, req1_, mem_rdy_, waitack_;
  logic [3:0] len, wst0, wst1;
  logic       l3, l2, l1, waitreq_, ready_, gnt0_, gnt1_, done_, tmo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  code_tbl [16];

  always #5 clk = ~clk;

  am2925_seq dut (
    .clk(clk), .rst_(rst_), .cyc_end(cyc_end), .len(len),
    .req0_(req0_), .req1_(req1_), .wst0(wst0), .wst1(wst1),
    .mem_rdy_(mem_rdy_), .waitack_(waitack_),
    .l3(l3), .l2(l2), .l1(l1), .waitreq_(waitreq_), .ready_(ready_),
    .gnt0_(gnt0_), .gnt1_(gnt1_), .done_(done_), .tmo(tmo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("gnt_exclusive", {31'd0, gnt0_ | gnt1_}, 32'd1);
    check("waitreq_ready_exclusive", {31'd0, waitreq_ | ready_}, 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_lcode", {29'd0, l3, l2, l1}, 32'd0);
    check("rst_waitreq", {31'd0, waitreq_}, 32'd1);
    check("rst_ready", {31'd0, ready_}, 32'd1);
    check("rst_gnt", {30'd0, gnt1_, gnt0_}, 32'd3);
    check("rst_done", {31'd0, done_}, 32'd1);
    check("rst_tmo", {31'd0, tmo}, 32'd0);
  endtask

  // One complete transaction from the granting cyc_end through the clock after RDY.
  // ack_dly < 0 holds waitack_ high; mem_to holds mem_rdy_ high (caller drives it).
  task automatic txn(input int ack_dly, input bit mem_to);
    logic [31:0] who;
    int wst, n;
    bit to;
    who = exp_q.pop_front();
    wst = (who == 0) ? int'(wst0) : int'(wst1);
    cyc_end = 1'b1; tick(); cyc_end = 1'b0;
    check("grant", {30'd0, gnt1_, gnt0_}, (who == 0) ? 32'd2 : 32'd1);
    check("waitreq_asserted", {31'd0, waitreq_}, 32'd0);
    check("tmo_cleared_on_grant", {31'd0, tmo}, 32'd0);
    if (ack_dly < 0) begin
      repeat (14) begin tick(); check("waitreq_hold", {31'd0, waitreq_}, 32'd0); end
      to = 1'b1;
    end else begin
      repeat (ack_dly) begin tick(); check("waitreq_hold", {31'd0, waitreq_}, 32'd0); end
      waitack_ = 1'b0; tick(); waitack_ = 1'b1;
      check("waitreq_released", {31'd0, waitreq_}, 32'd1);
      n = ((wst == 0) ? 1 : wst) + (mem_to ? 255 : 1);
      repeat (n - 1) begin
        tick();
        check("ready_not_yet", {30'd0, ready_, done_}, 32'd3);
        check("grant_held", {30'd0, gnt1_, gnt0_}, (who == 0) ? 32'd2 : 32'd1);
      end
      to = mem_to;
    end
    tick();
    check("rdy_pulse", {30'd0, ready_, done_}, 32'd0);
    check("rdy_gnt_released", {30'd0, gnt1_, gnt0_}, 32'd3);
    check("rdy_tmo", {31'd0, tmo}, {31'd0, to});
    tick();
    check("rdy_one_clk", {30'd0, ready_, done_}, 32'd3);
    check("tmo_holds", {31'd0, tmo}, {31'd0, to});
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    code_tbl = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b101, 3'b111, 3'b011,
                 3'b010, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    rst_ = 1'b1; cyc_end = 1'b0; len = 4'd0; req0_ = 1'b1; req1_ = 1'b1;
    wst0 = 4'd0; wst1 = 4'd0; mem_rdy_ = 1'b0; waitack_ = 1'b1;
    #2 rst_ = 1'b0;
    #2 check_reset_outputs();
    repeat (2) tick();
    rst_ = 1'b1;

    // Length-code sweep with a hold step after each pulse.
    for (int i = 0; i < 16; i++) begin
      len = 4'(i); cyc_end = 1'b1;
      exp_q.push_back({29'd0, code_tbl[i]});
      tick(); cyc_end = 1'b0;
      check($sformatf("lcode_len%0d", i), {29'd0, l3, l2, l1}, exp_q.pop_front());
      len = 4'((i + 5) % 16);
      tick();
      check($sformatf("lcode_hold_len%0d", i), {29'd0, l3, l2, l1}, {29'd0, code_tbl[i]});
    end
    check("no_grant_during_sweep", {30'd0, gnt1_, gnt0_}, 32'd3);

    // Request outside cyc_end, withdrawn before cyc_end: no grant.
    req1_ = 1'b0; tick(); tick();
    check("req_outside_cyc_end", {30'd0, gnt1_, gnt0_}, 32'd3);
    req1_ = 1'b1; cyc_end = 1'b1; tick(); cyc_end = 1'b0;
    check("withdrawn_no_grant", {30'd0, gnt1_, gnt0_}, 32'd3);
    check("withdrawn_no_waitreq", {31'd0, waitreq_}, 32'd1);

    // Single transaction, wst0=2, ack one clock after waitreq_.
    req0_ = 1'b0; wst0 = 4'd2; exp_q.push_back(0);
    txn(1, 1'b0);
    req0_ = 1'b1;

    // Wait-acknowledge timeout on requester 1.
    req1_ = 1'b0; wst1 = 4'd4; exp_q.push_back(1);
    txn(-1, 1'b0);
    req1_ = 1'b1;
    tick(); tick();
    check("tmo_held_idle", {31'd0, tmo}, 32'd1);

    // Round-robin with both requests held low.
    req0_ = 1'b0; req1_ = 1'b0; wst0 = 4'd0; wst1 = 4'd3;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    repeat (4) txn(1, 1'b0);
    req0_ = 1'b1; req1_ = 1'b1;

    // Memory watchdog timeout.
    req0_ = 1'b0; wst0 = 4'd1; mem_rdy_ = 1'b1; exp_q.push_back(0);
    txn(0, 1'b1);
    mem_rdy_ = 1'b0; req0_ = 1'b1;

    // Reset during COUNT, with requester 1 pending; requester 0 was granted last.
    len = 4'd9; req0_ = 1'b0; wst0 = 4'd6;
    cyc_end = 1'b1; tick(); cyc_end = 1'b0;
    check("midop_grant", {30'd0, gnt1_, gnt0_}, 32'd2);
    check("midop_lcode", {29'd0, l3, l2, l1}, 32'd6);
    waitack_ = 1'b0; tick(); waitack_ = 1'b1;
    check("midop_in_count", {31'd0, waitreq_}, 32'd1);
    req1_ = 1'b0;
    tick(); tick();
    rst_ = 1'b0;
    #2 check_reset_outputs();
    tick();
    rst_ = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1);
    txn(0, 1'b0);
    txn(0, 1'b0);
    req0_ = 1'b1; req1_ = 1'b1;
    tick();
    check("final_idle_gnt", {30'd0, gnt1_, gnt0_}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
